// File: rtl/fazyrv_adr_pkg.sv
// fazyrv_adr_pkg
//  Shared types and helpers for the chunk-serial address sequencer.
//  - adr_seq_state_t : sequencer state encoding
//  - chunks(bwidth)  : number of chunk shifts needed to fill 32 bits
//  - cnt_w(bwidth)   : width of a counter indexing those chunks (min 1)
//  - legal_bwidth()  : datapath widths the chunk-serial core supports
package fazyrv_adr_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    REQ   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } adr_seq_state_t;

  function automatic int chunks(input int bwidth);
    return 32 / bwidth;
  endfunction

  function automatic int cnt_w(input int bwidth);
    return (chunks(bwidth) > 1) ? $clog2(chunks(bwidth)) : 1;
  endfunction

  function automatic bit legal_bwidth(input int bwidth);
    return (bwidth == 1) || (bwidth == 2) || (bwidth == 4) ||
           (bwidth == 8) || (bwidth == 16) || (bwidth == 32);
  endfunction

endpackage

// File: rtl/fazyrv_chunk_cnt.sv
// fazyrv_chunk_cnt
//  Chunk index counter for chunk-serial units. Saturates at CHUNKS-1; the
//  only way back to 0 is an explicit clear (or reset).
//  Ports:
//   clk_i   in   clock, rising edge
//   rst_i   in   synchronous reset, active-high
//   clr_i   in   reload counter to 0
//   en_i    in   advance counter by one (held at CHUNKS-1)
//   cnt_o   out  current chunk index
//   last_o  out  counter sits at CHUNKS-1 (not qualified by en_i)
module fazyrv_chunk_cnt #(
  parameter  int CHUNKS = 4,
  localparam int CNTW   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [CNTW-1:0] cnt_o,
  output logic            last_o
);

  logic [CNTW-1:0] r_cnt;
  logic            w_last;

  assign w_last = (r_cnt == CNTW'(CHUNKS - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_cnt <= '0;
    end else if (en_i && !w_last) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_o  = r_cnt;
  assign last_o = w_last;

endmodule

// File: rtl/fazyrv_adr_seq.sv
// fazyrv_adr_seq
//  Sequencer for the chunk-serial address scratchpad. Shifts the scratchpad
//  for 32/BWIDTH cycles, then presents the assembled address on a req/ack
//  memory port and pulses done_o on completion. Shared by fetch and LSU.
//  Ports:
//   clk_i, rst_i        clock / synchronous active-high reset
//   start_i, lsu_i      start a sequence (IDLE/DONE only), access type
//   abort_i             cancel (trap/flush)
//   shft_o, cnt_o       scratchpad shift enable and chunk index
//   last_o              final shift cycle
//   adr_par_i           parallel scratchpad content
//   mem_req_o/ack_i     memory handshake, mem_adr_o/mem_lsu_o with request
//   busy_o, done_o      sequence in flight / one-cycle completion pulse
module fazyrv_adr_seq
  import fazyrv_adr_pkg::*;
#(
  parameter  int BWIDTH = 8,
  localparam int CHUNKS = chunks(BWIDTH),
  localparam int CNTW   = cnt_w(BWIDTH)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            lsu_i,
  input  logic            abort_i,
  output logic            shft_o,
  output logic [CNTW-1:0] cnt_o,
  output logic            last_o,
  input  logic [31:0]     adr_par_i,
  output logic            mem_req_o,
  input  logic            mem_ack_i,
  output logic [31:0]     mem_adr_o,
  output logic            mem_lsu_o,
  output logic            busy_o,
  output logic            done_o
);

  if (!legal_bwidth(BWIDTH)) begin : g_illegal_bwidth
    $error("fazyrv_adr_seq: BWIDTH must be 1, 2, 4, 8, 16 or 32");
  end

  adr_seq_state_t  r_state;
  adr_seq_state_t  w_state_next;
  logic            r_lsu;
  logic            w_lsu_next;
  logic            w_cnt_clr;
  logic            w_cnt_en;
  logic [CNTW-1:0] w_cnt;
  logic            w_last;
  logic            w_shft;
  logic            w_req;

  fazyrv_chunk_cnt #(.CHUNKS(CHUNKS)) u_chunk_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (w_cnt_clr),
    .en_i   (w_cnt_en),
    .cnt_o  (w_cnt),
    .last_o (w_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_lsu   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_lsu   <= w_lsu_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_lsu_next   = r_lsu;
    w_cnt_clr    = 1'b0;
    w_cnt_en     = 1'b0;
    case (r_state)
      // DONE behaves like IDLE so a new start can be taken back-to-back
      IDLE, DONE: begin
        w_state_next = IDLE;
        if (start_i && !abort_i) begin
          w_state_next = SHIFT;
          w_cnt_clr    = 1'b1;
          w_lsu_next   = lsu_i;
        end
      end
      SHIFT: begin
        if (abort_i) begin
          w_state_next = IDLE;
        end else begin
          w_cnt_en = 1'b1;
          if (w_last) w_state_next = REQ;
        end
      end
      REQ: begin
        if (mem_ack_i) begin
          w_state_next = abort_i ? IDLE : DONE;
        end else if (abort_i) begin
          // request already on the bus: wait for its ack without reporting
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_ack_i) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_shft    = (r_state == SHIFT);
  assign w_req     = (r_state == REQ) || (r_state == DRAIN);

  assign shft_o    = w_shft;
  assign cnt_o     = w_shft ? w_cnt : '0;
  assign last_o    = w_shft && w_last;
  assign mem_req_o = w_req;
  // instruction fetches are word aligned: drop the low address bits
  assign mem_adr_o = w_req ? {adr_par_i[31:2], adr_par_i[1:0] & {2{r_lsu}}} : 32'h0;
  assign mem_lsu_o = w_req && r_lsu;
  assign busy_o    = w_shft || w_req;
  assign done_o    = (r_state == DONE);

endmodule
